// File: rtl/qr_pkg.sv
// Shared constants, state type and byte-keep helper for the QR-CORDIC input loader.
package qr_pkg;

    localparam int TBITS   = 64;
    localparam int TBYTE   = TBITS / 8;
    localparam int NUM_COL = 8;
    localparam int CNT_W   = $clog2(NUM_COL);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ISSUE   = 2'd1,
        DISCARD = 2'd2
    } qr_state_t;

    // Disabled bytes are stored as zero so the array never sees stale lanes.
    function automatic logic [TBITS-1:0] keep_bytes(input logic [TBITS-1:0] data,
                                                    input logic [TBYTE-1:0] keep);
        logic [TBITS-1:0] res;
        res = '0;
        for (int b = 0; b < TBYTE; b++) begin
            res[8*b +: 8] = keep[b] ? data[8*b +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/qr_col_buffer.sv
// NUM_COL x TBITS column store: byte-masked write port, combinational read port.
module qr_col_buffer
    import qr_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_addr,
    input  logic [TBITS-1:0] wr_data,
    input  logic [TBYTE-1:0] wr_keep,
    input  logic [CNT_W-1:0] rd_addr,
    output logic [TBITS-1:0] rd_data
);

    logic [TBITS-1:0] mem [NUM_COL];

    // Contents are don't-care after reset, so no reset term on the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= keep_bytes(wr_data, wr_keep);
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/qr_axis_frame_loader.sv
// Collects one NUM_COL-beat AXIS frame, checks TLAST alignment, replays it column-wise.
module qr_axis_frame_loader
    import qr_pkg::*;
(
    input  logic             aclk,
    input  logic             areset,
    input  logic             S_AXIS_MM2S_TVALID,
    output logic             S_AXIS_MM2S_TREADY,
    input  logic [TBITS-1:0] S_AXIS_MM2S_TDATA,
    input  logic [TBYTE-1:0] S_AXIS_MM2S_TKEEP,
    input  logic             S_AXIS_MM2S_TLAST,
    output logic             col_valid,
    input  logic             col_ready,
    output logic [TBITS-1:0] col_data,
    output logic [CNT_W-1:0] col_idx,
    output logic             col_last,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COL - 1);

    qr_state_t        state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             tready_q, tready_d;
    logic             cvalid_q, cvalid_d;
    logic             err_q, err_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic             accept;
    logic             wr_en;

    assign accept = S_AXIS_MM2S_TVALID && tready_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= FILL;
            beat_q   <= '0;
            idx_q    <= '0;
            tready_q <= 1'b0;
            cvalid_q <= 1'b0;
            err_q    <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            idx_q    <= idx_d;
            tready_q <= tready_d;
            cvalid_q <= cvalid_d;
            err_q    <= err_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        idx_d    = idx_q;
        tready_d = tready_q;
        cvalid_d = cvalid_q;
        err_d    = 1'b0;
        fcnt_d   = fcnt_q;
        wr_en    = 1'b0;
        case (state_q)
            FILL: begin
                tready_d = 1'b1;
                if (accept) begin
                    wr_en = 1'b1;
                    if (beat_q == LAST_IDX) begin
                        beat_d = '0;
                        if (S_AXIS_MM2S_TLAST) begin
                            // TREADY drops on the same edge the final beat lands.
                            state_d  = ISSUE;
                            tready_d = 1'b0;
                            cvalid_d = 1'b1;
                            idx_d    = '0;
                        end else begin
                            state_d = DISCARD;
                            err_d   = 1'b1;
                        end
                    end else if (S_AXIS_MM2S_TLAST) begin
                        err_d  = 1'b1;
                        beat_d = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                tready_d = 1'b1;
                if (accept && S_AXIS_MM2S_TLAST) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            ISSUE: begin
                tready_d = 1'b0;
                if (cvalid_q && col_ready) begin
                    if (idx_q == LAST_IDX) begin
                        cvalid_d = 1'b0;
                        idx_d    = '0;
                        fcnt_d   = fcnt_q + 16'd1;
                        state_d  = FILL;
                        tready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = FILL;
                tready_d = 1'b0;
                cvalid_d = 1'b0;
            end
        endcase
    end

    qr_col_buffer u_col_buffer (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (beat_q),
        .wr_data (S_AXIS_MM2S_TDATA),
        .wr_keep (S_AXIS_MM2S_TKEEP),
        .rd_addr (idx_q),
        .rd_data (col_data)
    );

    assign S_AXIS_MM2S_TREADY = tready_q;
    assign col_valid          = cvalid_q;
    assign col_idx            = idx_q;
    assign col_last           = cvalid_q && (idx_q == LAST_IDX);
    assign frame_err          = err_q;
    assign frame_cnt          = fcnt_q;

endmodule

// File: tb/tb_qr_axis_frame_loader.sv
// Randomized bench for qr_axis_frame_loader against a frame-level reference model.
module tb_qr_axis_frame_loader;

    logic        aclk;
    logic        areset;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        col_valid;
    logic        col_ready;
    logic [63:0] col_data;
    logic [2:0]  col_idx;
    logic        col_last;
    logic        frame_err;
    logic [15:0] frame_cnt;

    qr_axis_frame_loader dut (
        .aclk               (aclk),
        .areset             (areset),
        .S_AXIS_MM2S_TVALID (tvalid),
        .S_AXIS_MM2S_TREADY (tready),
        .S_AXIS_MM2S_TDATA  (tdata),
        .S_AXIS_MM2S_TKEEP  (tkeep),
        .S_AXIS_MM2S_TLAST  (tlast),
        .col_valid          (col_valid),
        .col_ready          (col_ready),
        .col_data           (col_data),
        .col_idx            (col_idx),
        .col_last           (col_last),
        .frame_err          (frame_err),
        .frame_cnt          (frame_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        int          idx;
        bit          last;
    } col_t;

    col_t        exp_q[$];
    logic [63:0] fdata [16];
    logic [7:0]  fkeep [16];
    int          tests = 0;
    int          fails = 0;
    int          exp_err = 0;
    int          seen_err = 0;
    int          good_frames = 0;
    int          ready_mode = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [2:0]  prev_idx;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mask(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        r = 64'h0;
        for (int b = 0; b < 8; b++) begin
            if (k[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Scoreboard: every column handshake must match the next expected column.
    always @(negedge aclk) begin
        logic r;
        col_t e;
        cyc++;
        if (!mon_en) begin
            prev_stall = 1'b0;
            col_ready  = 1'b0;
        end else begin
            if (frame_err) seen_err++;
            if (prev_stall)
                check_val("stall_hold", 128'({col_valid, col_idx, col_data}),
                          128'({1'b1, prev_idx, prev_data}));
            if (col_valid) check_val("tready_in_issue", 128'(tready), 128'(0));
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = ((cyc % 3) == 0);
            endcase
            col_ready = r;
            if (col_valid && r) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_col", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_val("col_data", 128'(col_data), 128'(e.data));
                    check_val("col_idx", 128'(col_idx), 128'(e.idx));
                    check_val("col_last", 128'(col_last), 128'(e.last));
                end
            end
            prev_stall = col_valid && !r;
            prev_data  = col_data;
            prev_idx   = col_idx;
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        n = 0;
        while (!tready && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 2000) check_val("tready_timeout", 128'(0), 128'(1));
        @(negedge aclk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        if ($urandom_range(0, 3) == 0) @(negedge aclk);
    endtask

    task automatic send_frame(input int len);
        col_t c;
        if (len == 8) begin
            for (int i = 0; i < 8; i++) begin
                c.data = ref_mask(fdata[i], fkeep[i]);
                c.idx  = i;
                c.last = (i == 7);
                exp_q.push_back(c);
            end
            good_frames++;
        end else begin
            exp_err++;
        end
        for (int i = 0; i < len; i++) send_beat(fdata[i], fkeep[i], (i == len - 1));
    endtask

    task automatic fill_k_pattern();
        for (int i = 0; i < 16; i++) begin
            fdata[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
            fkeep[i] = 8'hFF;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            fdata[i] = {$urandom, $urandom};
            fkeep[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || col_valid) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check_val("drain_empty", 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        int n;
        int len;
        int r;
        areset    = 1'b0;
        tvalid    = 1'b0;
        tdata     = '0;
        tkeep     = '0;
        tlast     = 1'b0;
        col_ready = 1'b0;
        #1 areset = 1'b1;
        #1;
        check_val("rst_tready", 128'(tready), 128'(0));
        check_val("rst_col_valid", 128'(col_valid), 128'(0));
        check_val("rst_col_last", 128'(col_last), 128'(0));
        check_val("rst_col_idx", 128'(col_idx), 128'(0));
        check_val("rst_frame_err", 128'(frame_err), 128'(0));
        check_val("rst_frame_cnt", 128'(frame_cnt), 128'(0));
        repeat (2) @(negedge aclk);
        check_val("rst_hold_tready", 128'(tready), 128'(0));
        areset = 1'b0;
        mon_en = 1'b1;
        @(negedge aclk);
        check_val("tready_after_rst", 128'(tready), 128'(1));

        // Good frame k = 1..8 with the array always ready.
        ready_mode = 0;
        fill_k_pattern();
        send_frame(8);
        wait_drain();
        check_val("frame_cnt_1", 128'(frame_cnt), 128'(1));
        check_val("no_err_good", 128'(seen_err), 128'(0));

        // Same frame under 1,0,0 backpressure.
        ready_mode = 2;
        send_frame(8);
        wait_drain();
        check_val("frame_cnt_2", 128'(frame_cnt), 128'(2));

        // Reset while column 4 is on the bus.
        ready_mode = 0;
        send_frame(8);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!(col_valid && col_idx == 3'd4) && n < 200);
        check_val("reach_idx4", 128'(n < 200), 128'(1));
        #1 areset = 1'b1;
        mon_en = 1'b0;
        #1;
        check_val("midrst_col_valid", 128'(col_valid), 128'(0));
        check_val("midrst_tready", 128'(tready), 128'(0));
        check_val("midrst_frame_cnt", 128'(frame_cnt), 128'(0));
        exp_q.delete();
        good_frames = 0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        mon_en = 1'b1;
        @(negedge aclk);
        check_val("midrst_tready_rel", 128'(tready), 128'(1));
        check_val("midrst_cnt_rel", 128'(frame_cnt), 128'(0));

        // Byte masking on beat 3, then early and overlong framing, each followed by a good frame.
        ready_mode = 1;
        fill_random();
        fdata[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        fkeep[2] = 8'h0F;
        send_frame(8);
        fill_random();
        send_frame(5);
        fill_k_pattern();
        send_frame(8);
        fill_random();
        send_frame(11);
        fill_random();
        send_frame(8);
        wait_drain();
        check_val("err_pulses_dir", 128'(seen_err), 128'(exp_err));
        check_val("frame_cnt_dir", 128'(frame_cnt), 128'(good_frames));

        for (int f = 0; f < 40; f++) begin
            ready_mode = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 7)       len = 8;
            else if (r == 7) len = $urandom_range(1, 7);
            else             len = $urandom_range(9, 12);
            fill_random();
            send_frame(len);
        end
        wait_drain();
        check_val("err_pulses_rand", 128'(seen_err), 128'(exp_err));
        check_val("frame_cnt_rand", 128'(frame_cnt), 128'(good_frames[15:0]));
        check_val("idle_col_valid", 128'(col_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qr_axis_frame_loader.md
Name: qr_axis_frame_loader

Overview:
Input framing stage directly downstream of the 64-bit S_AXIS_MM2S DMA stream and upstream of the QR-CORDIC array inside yolo_top. It collects one NUM_COL-beat matrix frame into a local column buffer and validates TLAST alignment. It then replays the frame column-by-column to the CORDIC array over a valid/ready handshake. Misframed input is dropped and flagged, so the array only ever sees complete matrices.

Parameters:
TBITS, 64, AXIS data width; one beat = one matrix column
TBYTE, 8, TKEEP width (TBITS/8)
NUM_COL, 8, beats (columns) per frame; must be >= 2
CNT_W, 3, column index width, $clog2(NUM_COL)

Ports:
aclk  in  1  single clock for stream and core side
areset  in  1  asynchronous reset, active-high
S_AXIS_MM2S_TVALID  in  1  upstream beat valid
S_AXIS_MM2S_TREADY  out  1  loader can accept a beat
S_AXIS_MM2S_TDATA  in  TBITS  column data
S_AXIS_MM2S_TKEEP  in  TBYTE  byte enables; a disabled byte is stored as 0
S_AXIS_MM2S_TLAST  in  1  end of frame
col_valid  out  1  col_data valid toward the CORDIC array
col_ready  in  1  CORDIC array accepts a column
col_data  out  TBITS  buffered column
col_idx  out  CNT_W  column index 0..NUM_COL-1
col_last  out  1  high with column NUM_COL-1
frame_err  out  1  one-cycle pulse on a misframed input
frame_cnt  out  16  count of good frames issued, wraps at 2^16

Behaviour:
- Reset: areset is asynchronous. While it is asserted, state = FILL, beat/column counters = 0, TREADY = 0, col_valid = 0, col_last = 0, col_idx = 0, frame_err = 0, frame_cnt = 0. Buffer contents are don't-care.
- TREADY comes from a register. It is 1 in FILL and DISCARD and 0 in ISSUE. TREADY goes to 1 on the first clock edge after reset is released.
- A beat is accepted when TVALID && TREADY at a rising edge. Stored data per byte b = TKEEP[b] ? TDATA[8b+7:8b] : 8'h00.
- FILL state:
  - Accept beat into buf[beat_cnt] and increment beat_cnt.
  - TLAST with beat_cnt < NUM_COL-1 (early): discard the frame, pulse frame_err, beat_cnt = 0, stay in FILL.
  - beat_cnt == NUM_COL-1 with TLAST = 1: frame is good, go to ISSUE. TREADY drops in the same edge.
  - beat_cnt == NUM_COL-1 with TLAST = 0 (overlong): pulse frame_err and go to DISCARD.
- DISCARD state: swallow beats until a beat with TLAST is accepted, then beat_cnt = 0 and go to FILL. No extra frame_err pulse is generated.
- ISSUE state:
  - col_valid = 1 starting the cycle after the final beat is accepted (1-cycle latency). col_data = buf[col_idx].
  - Handshake is standard valid/ready. col_data, col_idx and col_last hold stable while col_valid && !col_ready; col_valid never drops without a handshake.
  - On each handshake col_idx increments.
  - On the handshake of col_idx == NUM_COL-1 (col_last = 1): col_valid drops, frame_cnt increments, state = FILL, and TREADY is 1 the next cycle.
- Throughput: with col_ready held at 1, one frame takes NUM_COL accept cycles + NUM_COL issue cycles = 16 cycles at the defaults.
- Reset asserted mid-frame (FILL or ISSUE): everything is aborted immediately. There is no partial output after release.
- TVALID held with TREADY = 0 in ISSUE: the beat is not consumed and the upstream holds it.

Decomposition:
- Shared package qr_pkg: TBITS, TBYTE, NUM_COL, CNT_W, and a state enum {FILL, ISSUE, DISCARD}. The state enum is shared with the output packer.
- One natural sub-module: qr_col_buffer. It is an NUM_COL x TBITS register file with a byte-masked write port (TKEEP) and a combinational read port indexed by col_idx.
- The FSM and counters stay in the top-level loader.

Test Plan:
- Good frame: 8 beats of 64'h0101..01 x k (k = 1..8), TLAST on beat 8, col_ready = 1 -> col_data sequence matches k = 1..8; col_idx 0..7; col_last only at idx 7; frame_cnt = 1; frame_err never pulses.
- Backpressure: good frame, col_ready toggling 1,0,0,1,... -> every column is issued exactly once in order, outputs stay stable while stalled, and TREADY stays 0 until the col_last handshake.
- Early TLAST: TLAST on beat 5, then a good 8-beat frame -> one frame_err pulse after beat 5, no col_valid for the bad frame, the good frame is issued intact, frame_cnt = 1.
- Overlong frame: 11 beats with TLAST on beat 11, then a good frame -> frame_err pulses on beat 8, beats 9–11 are swallowed, the next frame is issued correctly.
- TKEEP masking: beat 3 has TKEEP = 8'h0F and TDATA = 64'hFFFF_FFFF_FFFF_FFFF -> column 2 is issued as 64'h0000_0000_FFFF_FFFF.
- Reset mid-issue: assert areset while col_idx = 4 -> col_valid = 0 and TREADY = 0 asynchronously. After release, TREADY = 1 next edge, frame_cnt = 0, and a fresh frame is issued from col_idx 0.
